// File: rtl/avalon_ram_agent_pkg.sv
// Shared types for the Avalon RAM agent: FSM state encoding, read-pipeline beat
// and the word returned for out-of-range reads.
package Types;

  typedef logic [31:0] uint32_t;

  typedef enum logic {
    AGENT_IDLE  = 1'b0,
    AGENT_STALL = 1'b1
  } agent_state_t;

  typedef struct packed {
    logic    vld;
    uint32_t data;
  } rd_beat_t;

  localparam uint32_t BOUNDS_POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_ram_agent_read_delay_line.sv
// READ_LATENCY-deep valid/data shift register; the output data word only moves
// when a valid beat reaches it, so it holds between responses.
module read_delay_line
  import Types::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rd_beat_t in_beat,
  output logic     readdatavalid,
  output uint32_t  agent_to_host
);

  logic [READ_LATENCY:0]        vld_pipe;
  logic [READ_LATENCY:1]        vld_q;
  logic [READ_LATENCY:0][31:0]  data_pipe;
  logic [READ_LATENCY:1][31:0]  data_q;

  assign vld_pipe  = {vld_q, in_beat.vld};
  assign data_pipe = {data_q, in_beat.data};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_pipe[READ_LATENCY-1:0];
      for (int k = 1; k <= READ_LATENCY; k++)
        if (vld_pipe[k-1]) data_q[k] <= data_pipe[k-1];
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY];
  assign agent_to_host = data_q[READ_LATENCY];

endmodule

// File: rtl/avalon_ram_agent.sv
// Avalon-MM RAM agent: fixed wait-state stall FSM, byte-enabled word memory and
// pipelined read return. Define RAM_AGENT_BOUNDS_EN for out-of-range detection.
module avalon_ram_agent
  import Types::*;
#(
  parameter int WORDS        = 1024,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  uint32_t    address,
  input  logic [3:0] byteenable,
  input  logic       read,
  input  logic       write,
  input  uint32_t    host_to_agent,
  output logic       waitrequest,
  output uint32_t    agent_to_host,
  output logic       readdatavalid
`ifdef RAM_AGENT_BOUNDS_EN
  ,
  output logic       bounds_error
`endif
);

  localparam int         AW  = $clog2(WORDS);
  localparam logic [3:0] WS4 = WAIT_STATES[3:0];

  agent_state_t   state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic           req, fsm_wait, accept, acc_ok, oob;
  logic [AW-1:0]  idx;
  uint32_t        mem [WORDS];
  rd_beat_t       rd_beat;

  assign req = read | write;
  assign idx = address[AW+1:2];

`ifdef RAM_AGENT_BOUNDS_EN
  assign oob = address >= 32'(WORDS * 4);
`else
  logic unused_addr;
  assign oob         = 1'b0;
  assign unused_addr = ^{address[31:AW+2], address[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AGENT_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      AGENT_IDLE:
        if (req && WAIT_STATES != 0) begin
          state_nxt = AGENT_STALL;
          cnt_nxt   = 4'd1;
        end
      AGENT_STALL:
        if (!req || cnt >= WS4) begin
          state_nxt = AGENT_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
    endcase
  end

  always_comb begin
    fsm_wait = 1'b0;
    accept   = 1'b0;
    unique case (state)
      AGENT_IDLE:
        if (req) begin
          fsm_wait = (WAIT_STATES != 0);
          accept   = (WAIT_STATES == 0);
        end
      AGENT_STALL:
        if (req) begin
          fsm_wait = cnt < WS4;
          accept   = cnt >= WS4;
        end
    endcase
  end

  // A request seen while rst is high is held off so it is never half-accepted.
  assign waitrequest = req & (rst | fsm_wait);
  assign acc_ok      = accept & ~rst;

  always_ff @(posedge clk)
    if (acc_ok && write && !oob)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[idx][8*b +: 8] <= host_to_agent[8*b +: 8];

  // Read+write together performs only the write.
  assign rd_beat.vld  = acc_ok & read & ~write;
  assign rd_beat.data = oob ? BOUNDS_POISON : mem[idx];

  read_delay_line #(.READ_LATENCY(READ_LATENCY)) u_rdl (
    .clk           (clk),
    .rst           (rst),
    .in_beat       (rd_beat),
    .readdatavalid (readdatavalid),
    .agent_to_host (agent_to_host)
  );

`ifdef RAM_AGENT_BOUNDS_EN
  always_ff @(posedge clk)
    if (rst)                bounds_error <= 1'b0;
    else if (acc_ok && oob) bounds_error <= 1'b1;
`endif

endmodule

// File: doc/avalon_ram_agent.md
AVALON_RAM_AGENT -- requirements
Module: avalon_ram_agent

Interface
REQ-001 Parameter WORDS, default 1024, memory depth in 32-bit words; SHALL be a power of two, at least 2.
REQ-002 Parameter WAIT_STATES, default 1, stall cycles inserted before each transfer is accepted; range 0..15.
REQ-003 Parameter READ_LATENCY, default 1, cycles from read acceptance to readdatavalid; range 1..8.
REQ-004 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port address, input, uint32_t, byte address; bits [1:0] ignored.
REQ-007 Port byteenable, input, 4, per-byte write enable; ignored for reads.
REQ-008 Port read, input, 1, host read request.
REQ-009 Port write, input, 1, host write request.
REQ-010 Port host_to_agent, input, uint32_t, write data.
REQ-011 Port waitrequest, output, 1, agent stall; transfer accepted in any cycle with (read|write) high and waitrequest low.
REQ-012 Port agent_to_host, output, uint32_t, read data.
REQ-013 Port readdatavalid, output, 1, agent_to_host valid this cycle.
REQ-014 Port bounds_error, output, 1, present only under REQ-031.

Function
REQ-015 Word index SHALL be address[log2(WORDS)+1:2]; higher bits are discarded (wrap) unless REQ-031 applies.
REQ-016 FSM states SHALL be AGENT_IDLE and AGENT_STALL, with a 4-bit stall counter cnt.
REQ-017 AGENT_IDLE with request and WAIT_STATES==0: waitrequest=0, accept the transfer, remain in AGENT_IDLE.
REQ-018 AGENT_IDLE with request and WAIT_STATES>0: waitrequest=1, next state AGENT_STALL, cnt=1.
REQ-019 AGENT_STALL with cnt<WAIT_STATES: waitrequest=1, cnt increments.
REQ-020 AGENT_STALL with cnt==WAIT_STATES: waitrequest=0, accept the transfer, next state AGENT_IDLE.
REQ-021 AGENT_STALL with read and write both low (host withdrawal): waitrequest=0, next state AGENT_IDLE, no access.
REQ-022 waitrequest SHALL be 0 whenever read and write are both low.
REQ-023 Accepted write: on the accept edge, each byte lane i with byteenable[i]=1 is updated; byteenable=4'b0000 leaves memory unchanged.
REQ-024 Accepted read sampled at edge T SHALL drive readdatavalid=1 with data in cycle T+READ_LATENCY, for exactly one cycle.
REQ-025 Up to READ_LATENCY reads SHALL be outstanding; responses return in acceptance order; back-to-back reads with WAIT_STATES=0 give back-to-back readdatavalid.
REQ-026 A read accepted one cycle after a write to the same word SHALL return the written data.
REQ-027 read and write high together: the write is performed, the read is dropped, and no readdatavalid is produced.
REQ-028 agent_to_host SHALL hold its last value while readdatavalid=0.

Reset
REQ-029 With rst high at an edge, the block SHALL enter AGENT_IDLE with cnt=0, every pipeline valid bit=0, readdatavalid=0, agent_to_host=0 and bounds_error=0; waitrequest=0 in the following cycle unless a request is present.
REQ-030 Reset mid-operation: pending reads are discarded with no readdatavalid; a stalled request restarts its stall count; memory contents are preserved.

Configuration
REQ-031 Macro RAM_AGENT_BOUNDS_EN defined: address >= WORDS*4 drops writes, returns 32'hDEAD_BEEF with normal latency for reads, and sets bounds_error, which is sticky until rst.
REQ-032 Macro RAM_AGENT_BOUNDS_EN undefined: the bounds_error port is absent and addresses wrap per REQ-015.

Structure
REQ-033 Package Types SHALL gain typedef agent_state_t (AGENT_IDLE, AGENT_STALL) and constant BOUNDS_POISON = 32'hDEAD_BEEF; uint32_t is reused from Types.
REQ-034 Sub-module read_delay_line: a READ_LATENCY-deep valid/data shift register producing readdatavalid and agent_to_host.
REQ-035 Ports SHALL be connectable one-to-one to the AvalonMmRw interface signals.

Verification (WAIT_STATES=1, READ_LATENCY=2, WORDS=1024 unless stated)
REQ-036 Write 32'h1234_5678 to 0x10 with byteenable=4'hF, then read 0x10: waitrequest high for 1 cycle on each transfer; readdatavalid 2 cycles after read acceptance with 32'h1234_5678.
REQ-037 Write 32'hAABB_CCDD to 0x20 (4'hF), then write 32'h0000_0011 (4'b0001), then read: returns 32'hAABB_CC11.
REQ-038 WAIT_STATES=0: four consecutive reads of 0x0, 0x4, 0x8, 0xC: waitrequest never high; four consecutive readdatavalid pulses in order.
REQ-039 Two reads accepted, rst asserted one cycle later: no readdatavalid afterwards; a prior write to 0x30 still reads back correctly.
REQ-040 Write 32'h5 to 0x1000 (WORDS=1024): without the macro, 0x0 reads 32'h5; with RAM_AGENT_BOUNDS_EN, the read returns 32'hDEAD_BEEF, bounds_error=1, and 0x0 is unchanged.
REQ-041 read and write both high to 0x40 with data 32'h77: no readdatavalid; a subsequent read of 0x40 returns 32'h77.
